// File: rtl/irq_ctrl.sv
// Priority interrupt controller: synchronized sources, enable/threshold/priority CSRs, claim/complete.
// Latency: line to g_interrupt 3 cycles; register reads return the cycle after reg_re.
// No backpressure; IRQ_EDGE_EN adds an EDGE register making selected sources rising-edge triggered.
module irq_ctrl #(
    parameter int NSRC   = 4,
    parameter int PRIO_W = 3
) (
    input  logic        clk,
    input  logic        rst_pipe,
    input  logic [NSRC-1:0] interrupt_in,
    input  logic        csr_meie,
    input  logic        reg_we,
    input  logic [3:0]  reg_wadr,
    input  logic [31:0] reg_wdata,
    input  logic        reg_re,
    input  logic [3:0]  reg_radr,
    output logic [31:0] reg_rdata,
    output logic        g_interrupt
);

    logic [NSRC-1:0]   sync1, sync2, sync3;
    logic [NSRC-1:0]   enable_q, in_service, edge_pend, edge_q;
    logic [PRIO_W-1:0] thresh_q;
    logic [PRIO_W-1:0] prio_q [NSRC];
    logic [NSRC-1:0]   pending, cand, rise, claim_mask, cmpl_mask;
    logic [PRIO_W-1:0] best_prio;
    logic [2:0]        win_idx;
    logic              win_vld;
    logic [3:0]        claim_id;
    logic              claim_fire, cmpl_fire;
    logic [31:0]       rdata_nxt;
    logic              unused_wdata;

    assign unused_wdata = ^reg_wdata;

    always_ff @(posedge clk) begin
        if (rst_pipe) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= interrupt_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    // Edge-pending bits stay visible while in service; level bits are hidden by it.
    assign pending = (edge_q & edge_pend) | (~edge_q & sync2 & ~in_service);
    assign cand    = pending & enable_q & ~in_service;

    always_comb begin
        win_vld   = 1'b0;
        win_idx   = 3'd0;
        best_prio = '0;
        // Strict compare keeps the lowest index on a priority tie.
        for (int i = 0; i < NSRC; i++) begin
            if (cand[i] && (prio_q[i] > thresh_q) && (prio_q[i] > best_prio)) begin
                win_vld   = 1'b1;
                win_idx   = 3'(i);
                best_prio = prio_q[i];
            end
        end
    end

    assign claim_id   = win_vld ? ({1'b0, win_idx} + 4'd1) : 4'd0;
    assign claim_fire = reg_re && (reg_radr == 4'h3) && win_vld;
    assign cmpl_fire  = reg_we && (reg_wadr == 4'h3);

    always_comb begin
        claim_mask = '0;
        cmpl_mask  = '0;
        for (int i = 0; i < NSRC; i++) begin
            claim_mask[i] = claim_fire && (win_idx == 3'(i));
            cmpl_mask[i]  = cmpl_fire && (reg_wdata[3:0] == 4'(i + 1));
        end
    end

    // Claim never picks an in-service source, so set and clear cannot collide.
    always_ff @(posedge clk) begin
        if (rst_pipe) begin
            in_service <= '0;
            edge_pend  <= '0;
        end else begin
            in_service <= (in_service & ~cmpl_mask) | claim_mask;
            edge_pend  <= (edge_pend & ~claim_mask) | (rise & edge_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_pipe) begin
            enable_q <= '0;
            thresh_q <= '0;
            for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
        end else if (reg_we) begin
            if (reg_wadr == 4'h1) enable_q <= reg_wdata[NSRC-1:0];
            if (reg_wadr == 4'h2) thresh_q <= reg_wdata[PRIO_W-1:0];
            for (int i = 0; i < NSRC; i++) begin
                if (reg_wadr == 4'(8 + i)) prio_q[i] <= reg_wdata[PRIO_W-1:0];
            end
        end
    end

`ifdef IRQ_EDGE_EN
    always_ff @(posedge clk) begin
        if (rst_pipe) begin
            edge_q <= '0;
        end else if (reg_we && (reg_wadr == 4'h4)) begin
            edge_q <= reg_wdata[NSRC-1:0];
        end
    end
`else
    assign edge_q = '0;
`endif

    always_comb begin
        rdata_nxt = '0;
        case (reg_radr)
            4'h0:    rdata_nxt = 32'(pending);
            4'h1:    rdata_nxt = 32'(enable_q);
            4'h2:    rdata_nxt = 32'(thresh_q);
            4'h3:    rdata_nxt = 32'(claim_id);
            4'h4:    rdata_nxt = 32'(edge_q);
            default: rdata_nxt = '0;
        endcase
        for (int i = 0; i < NSRC; i++) begin
            if (reg_radr == 4'(8 + i)) rdata_nxt = 32'(prio_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_pipe) begin
            reg_rdata   <= '0;
            g_interrupt <= 1'b0;
        end else begin
            if (reg_re) reg_rdata <= rdata_nxt;
            g_interrupt <= win_vld && csr_meie;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed scoreboard bench for irq_ctrl (NSRC=4, PRIO_W=3); edge scenario built when IRQ_EDGE_EN is defined.
module tb_irq_ctrl;
    localparam int NSRC   = 4;
    localparam int PRIO_W = 3;

    logic        clk = 1'b0;
    logic        rst_pipe;
    logic [NSRC-1:0] interrupt_in;
    logic        csr_meie;
    logic        reg_we;
    logic [3:0]  reg_wadr;
    logic [31:0] reg_wdata;
    logic        reg_re;
    logic [3:0]  reg_radr;
    logic [31:0] reg_rdata;
    logic        g_interrupt;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
        .clk          (clk),
        .rst_pipe     (rst_pipe),
        .interrupt_in (interrupt_in),
        .csr_meie     (csr_meie),
        .reg_we       (reg_we),
        .reg_wadr     (reg_wadr),
        .reg_wdata    (reg_wdata),
        .reg_re       (reg_re),
        .reg_radr     (reg_radr),
        .reg_rdata    (reg_rdata),
        .g_interrupt  (g_interrupt)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        re_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) re_seen <= reg_re;

    always @(negedge clk) begin
        if (re_seen) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check(tag_q.pop_front(), reg_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string tag);
        reg_re   = 1'b1;
        reg_radr = adr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        reg_re = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat);
        reg_we    = 1'b1;
        reg_wadr  = adr;
        reg_wdata = dat;
        @(negedge clk);
        reg_we = 1'b0;
    endtask

    task automatic claim_and_complete(input logic [31:0] k, input logic [31:0] exp, input string tag);
        reg_we    = 1'b1;
        reg_wadr  = 4'h3;
        reg_wdata = k;
        reg_re    = 1'b1;
        reg_radr  = 4'h3;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        reg_we = 1'b0;
        reg_re = 1'b0;
    endtask

    task automatic wait_g(input logic exp, input int max_cyc, input string tag);
        for (int i = 0; i < max_cyc && g_interrupt !== exp; i++) @(negedge clk);
        check(tag, 32'(g_interrupt), 32'(exp));
    endtask

    initial begin
        rst_pipe     = 1'b1;
        interrupt_in = '0;
        csr_meie     = 1'b0;
        reg_we       = 1'b0;
        reg_wadr     = '0;
        reg_wdata    = '0;
        reg_re       = 1'b0;
        reg_radr     = '0;
        cyc(3);
        check("rst_rdata", reg_rdata, 32'd0);
        check("rst_g", 32'(g_interrupt), 32'd0);
        rst_pipe = 1'b0;
        for (int a = 0; a < 12; a++) begin
            if (a < 5 || a >= 8) rd(4'(a), 32'd0, $sformatf("rst_reg%0d", a));
        end

        // Single level source, claim, complete with line still high
        wr(4'h1, 32'hF);
        wr(4'hA, 32'd3);
        wr(4'h2, 32'd0);
        csr_meie = 1'b1;
        interrupt_in[2] = 1'b1;
        wait_g(1'b1, 6, "s1_g_rise");
        rd(4'h0, 32'h4, "s1_pending");
        rd(4'h3, 32'd3, "s1_claim");
        cyc(1);
        check("s1_g_fall", 32'(g_interrupt), 32'd0);
        rd(4'h0, 32'h0, "s1_pending_masked");
        wr(4'h3, 32'd3);
        cyc(1);
        check("s1_g_again", 32'(g_interrupt), 32'd1);
        rd(4'h3, 32'd3, "s1_claim2");
        interrupt_in[2] = 1'b0;
        cyc(3);
        wr(4'h3, 32'd3);
        cyc(2);
        check("s1_idle", 32'(g_interrupt), 32'd0);

        // Equal priorities: lowest index first; claim in complete cycle sees pre-complete state
        wr(4'h9, 32'd2);
        wr(4'hB, 32'd2);
        interrupt_in[1] = 1'b1;
        interrupt_in[3] = 1'b1;
        cyc(4);
        rd(4'h3, 32'd2, "s2_tie_low_idx");
        claim_and_complete(32'd2, 32'd4, "s2_claim_pre_complete");
        rd(4'h3, 32'd2, "s2_reclaim");
        rd(4'h3, 32'd0, "s2_claim_empty");
        interrupt_in[1] = 1'b0;
        interrupt_in[3] = 1'b0;
        cyc(3);
        wr(4'h3, 32'd2);
        wr(4'h3, 32'd4);
        wr(4'h9, 32'd0);
        wr(4'hB, 32'd0);
        cyc(2);
        check("s2_idle", 32'(g_interrupt), 32'd0);

        // Threshold boundary
        wr(4'h8, 32'd5);
        wr(4'h2, 32'd5);
        interrupt_in[0] = 1'b1;
        cyc(5);
        check("s3_thr_equal_blocks", 32'(g_interrupt), 32'd0);
        rd(4'h3, 32'd0, "s3_claim_none");
        wr(4'h2, 32'd4);
        cyc(1);
        check("s3_thr_below", 32'(g_interrupt), 32'd1);
        rd(4'h2, 32'd4, "s3_thr_readback");

        // Global enable off still allows claim
        csr_meie = 1'b0;
        cyc(2);
        check("s4_meie_off", 32'(g_interrupt), 32'd0);
        rd(4'h3, 32'd1, "s4_claim_meie_off");
        interrupt_in[0] = 1'b0;
        cyc(3);
        wr(4'h3, 32'd1);
        csr_meie = 1'b1;
        wr(4'h2, 32'd0);
        cyc(2);
        check("s4_idle", 32'(g_interrupt), 32'd0);

`ifdef IRQ_EDGE_EN
        wr(4'h4, 32'h1);
        rd(4'h4, 32'h1, "s5_edge_readback");
        wr(4'h8, 32'd1);
        interrupt_in[0] = 1'b1;
        cyc(1);
        interrupt_in[0] = 1'b0;
        cyc(4);
        rd(4'h0, 32'h1, "s5_edge_pending");
        check("s5_g_edge", 32'(g_interrupt), 32'd1);
        interrupt_in[0] = 1'b1;
        cyc(1);
        interrupt_in[0] = 1'b0;
        cyc(1);
        rd(4'h3, 32'd1, "s5_claim_with_pulse");
        rd(4'h0, 32'h1, "s5_pending_kept");
        wr(4'h3, 32'd1);
        rd(4'h3, 32'd1, "s5_claim_again");
        wr(4'h3, 32'd1);
        rd(4'h0, 32'h0, "s5_pending_clear");
        wr(4'h4, 32'h0);
`else
        wr(4'h4, 32'h1);
        rd(4'h4, 32'h0, "s5_edge_absent");
`endif
        wr(4'h8, 32'd0);

        // Reset while source 2 is in service
        interrupt_in[2] = 1'b1;
        cyc(4);
        rd(4'h3, 32'd3, "s6_claim");
        rst_pipe = 1'b1;
        interrupt_in[2] = 1'b0;
        cyc(2);
        check("s6_rst_rdata", reg_rdata, 32'd0);
        check("s6_rst_g", 32'(g_interrupt), 32'd0);
        rst_pipe = 1'b0;
        wr(4'h3, 32'd9);
        for (int a = 0; a < 12; a++) begin
            if (a < 5 || a >= 8) rd(4'(a), 32'd0, $sformatf("s6_reg%0d", a));
        end
        interrupt_in[2] = 1'b1;
        cyc(5);
        check("s6_no_irq_unprogrammed", 32'(g_interrupt), 32'd0);
        rd(4'h3, 32'd0, "s6_claim_zero");
        rd(4'h0, 32'h4, "s6_pending_level");

        interrupt_in = '0;
        cyc(3);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
